level_event_arbiter: RTL and testbench

Multi-channel asynchronous level-change event scheduler. Each of N asynchronous level inputs is synchronized with a two-flop synchronizer and edge-detected. Detected changes are latched as pending events, and a round-robin arbiter serializes them onto one valid/ready event port. It sits between raw asynchronous status and interrupt lines and the single-consumer event handler (register block or IRQ controller) in the `clk` domain.

---
 rtl/level_event_arbiter.sv | 138 +++++++++++++
 tb/tb_level_event_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/level_event_arbiter.sv
// level_event_arbiter
//   Synchronizes N asynchronous level inputs, detects level changes and
//   latches them as pending events. A round-robin arbiter presents them one
//   at a time on a valid/ready event port.
//
// Parameters
//   N          number of asynchronous channels (2..32)
//   INIT_STATE reset value of the synchronizer and history flops
//   EDGE_MODE  0 = rising, 1 = falling, 2 = both edges
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high reset
//   async      asynchronous level inputs, one per channel
//   evt_valid  an event is presented
//   evt_ready  consumer accepts the presented event
//   evt_id     channel index of the presented event
//   evt_level  synchronized level of that channel when its edge was seen
//   pending    latched events not yet presented
//   overflow   sticky per-channel event-lost flag
//   ovf_clr    per-bit clear of overflow (a simultaneous new overflow wins)
module level_event_arbiter #(
  parameter int unsigned N          = 4,
  parameter logic        INIT_STATE = 1'b0,
  parameter int unsigned EDGE_MODE  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         async,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_id,
  output logic                 evt_level,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         overflow,
  input  logic [N-1:0]         ovf_clr
);

  localparam int unsigned IDW = $clog2(N);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state, state_d;

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [N-1:0] s1;
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [N-1:0] s2;
  logic [N-1:0]   s3;
  logic [N-1:0]   edge_det;
  logic [N-1:0]   lvl;
  logic [N-1:0]   hi_mask;
  logic [N-1:0]   req_hi;
  logic [N-1:0]   grant_oh;
  logic [IDW-1:0] last;
  logic [IDW-1:0] grant;
  logic           take;
  logic           any_pend;
  logic           do_grant;

  always_comb begin
    case (EDGE_MODE)
      0:       edge_det = s2 & ~s3;
      1:       edge_det = ~s2 & s3;
      default: edge_det = s2 ^ s3;
    endcase
  end

  // Round-robin search from last+1 with wrap: prefer the lowest pending
  // channel above last; otherwise the lowest pending channel overall.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = (i > 32'(last));
    end
    req_hi = pending & hi_mask;
    grant  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (pending[N-1-k]) grant = IDW'(N-1-k);
    end
    if (|req_hi) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (req_hi[N-1-k]) grant = IDW'(N-1-k);
      end
    end
  end

  assign any_pend  = |pending;
  // The output register may load when empty or when its event leaves now.
  assign take      = (state == EMPTY) || evt_ready;
  assign do_grant  = take && any_pend;
  assign grant_oh  = do_grant ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
  assign evt_valid = (state == FULL);

  always_comb begin
    state_d = state;
    if (take) begin
      state_d = any_pend ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= {N{INIT_STATE}};
      s2        <= {N{INIT_STATE}};
      s3        <= {N{INIT_STATE}};
      lvl       <= '0;
      pending   <= '0;
      overflow  <= '0;
      evt_id    <= '0;
      evt_level <= 1'b0;
      last      <= IDW'(N-1);
    end else begin
      s1 <= async;
      s2 <= s1;
      s3 <= s2;
      // A new edge on the channel being granted re-arms pending without
      // counting as a lost event.
      pending  <= (pending & ~grant_oh) | edge_det;
      overflow <= (overflow & ~ovf_clr) | (edge_det & pending & ~grant_oh);
      lvl      <= (lvl & ~edge_det) | (s2 & edge_det);
      if (do_grant) begin
        evt_id    <= grant;
        evt_level <= lvl[grant];
        last      <= grant;
      end
    end
  end

endmodule

// File: tb/tb_level_event_arbiter.sv
module tb_level_event_arbiter;

  typedef logic [2:0] exp_t; // {id[1:0], level}

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] async_a, async_r, async_i;
  logic       ready_a, ready_r, ready_i;
  logic       valid_a, valid_r, valid_i;
  logic [1:0] id_a, id_r, id_i;
  logic       lvl_a, lvl_r, lvl_i;
  logic [3:0] pend_a, pend_r, pend_i;
  logic [3:0] ovf_a, ovf_r, ovf_i;
  logic [3:0] clr_a, clr_r, clr_i;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  level_event_arbiter #(.N(4), .INIT_STATE(1'b0), .EDGE_MODE(2)) dut (
    .clk(clk), .reset(reset), .async(async_a), .evt_valid(valid_a),
    .evt_ready(ready_a), .evt_id(id_a), .evt_level(lvl_a),
    .pending(pend_a), .overflow(ovf_a), .ovf_clr(clr_a));

  level_event_arbiter #(.N(4), .INIT_STATE(1'b0), .EDGE_MODE(0)) dut_r (
    .clk(clk), .reset(reset), .async(async_r), .evt_valid(valid_r),
    .evt_ready(ready_r), .evt_id(id_r), .evt_level(lvl_r),
    .pending(pend_r), .overflow(ovf_r), .ovf_clr(clr_r));

  level_event_arbiter #(.N(4), .INIT_STATE(1'b1), .EDGE_MODE(2)) dut_i (
    .clk(clk), .reset(reset), .async(async_i), .evt_valid(valid_i),
    .evt_ready(ready_i), .evt_id(id_i), .evt_level(lvl_i),
    .pending(pend_i), .overflow(ovf_i), .ovf_clr(clr_i));

  task automatic do_reset();
    reset   = 1'b1;
    async_a = '0;  async_r = '0;  async_i = '1;
    ready_a = 1'b0; ready_r = 1'b1; ready_i = 1'b1;
    clr_a   = '0;  clr_r = '0;  clr_i = '0;
    q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (valid_a !== 1'b0) $display("FAIL rst_valid got %b want 0", valid_a); else n_pass++;
    n_checks++; if (id_a !== 2'd0) $display("FAIL rst_id got %0d want 0", id_a); else n_pass++;
    n_checks++; if (lvl_a !== 1'b0) $display("FAIL rst_level got %b want 0", lvl_a); else n_pass++;
    n_checks++; if (pend_a !== 4'b0000) $display("FAIL rst_pending got %b want 0000", pend_a); else n_pass++;
    n_checks++; if (ovf_a !== 4'b0000) $display("FAIL rst_overflow got %b want 0000", ovf_a); else n_pass++;
    n_checks++; if ({valid_r, valid_i} !== 2'b00) $display("FAIL rst_valid_variants got %b want 00", {valid_r, valid_i}); else n_pass++;
  endtask

  task automatic test_latency();
    int first = 0;
    int nvalid = 0;
    do_reset();
    ready_a = 1'b1;
    async_a[2] = 1'b1;
    q.push_back({2'd2, 1'b1});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3) begin
        n_checks++; if (pend_a !== 4'b0100) $display("FAIL lat_pending got %b want 0100", pend_a); else n_pass++;
      end
      if (valid_a) begin
        nvalid++;
        if (first == 0) first = c;
      end
      if (valid_a && ready_a) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL lat_unexpected got id %0d want none", id_a);
        else begin
          e = q.pop_front();
          if ({id_a, lvl_a} !== e) $display("FAIL lat_event got %b want %b", {id_a, lvl_a}, e); else n_pass++;
        end
      end
    end
    n_checks++; if (first !== 4) $display("FAIL lat_cycle got %0d want 4", first); else n_pass++;
    n_checks++; if (nvalid !== 1) $display("FAIL lat_valid_cycles got %0d want 1", nvalid); else n_pass++;
    n_checks++; if (pend_a !== 4'b0000) $display("FAIL lat_pending_after got %b want 0000", pend_a); else n_pass++;
    n_checks++; if (q.size() !== 0) $display("FAIL lat_timeout got %0d left want 0", q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first = 0;
    int lastc = 0;
    do_reset();
    ready_a = 1'b1;
    async_a = 4'hF;
    for (int unsigned i = 0; i < 4; i++) q.push_back({2'(i), 1'b1});
    for (int c = 1; c <= 12 && q.size() > 0; c++) begin
      @(negedge clk);
      if (valid_a && ready_a) begin
        e = q.pop_front();
        n_checks++;
        if ({id_a, lvl_a} !== e) $display("FAIL b2b_event got %b want %b", {id_a, lvl_a}, e); else n_pass++;
        if (first == 0) first = c;
        lastc = c;
      end
    end
    n_checks++; if (q.size() !== 0) $display("FAIL b2b_timeout got %0d left want 0", q.size()); else n_pass++;
    n_checks++; if (lastc - first !== 3) $display("FAIL b2b_spacing got %0d want 3", lastc - first); else n_pass++;
    n_checks++; if (ovf_a !== 4'b0000) $display("FAIL b2b_overflow got %b want 0000", ovf_a); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    ready_a = 1'b0;
    q.push_back({2'd1, 1'b1});
    q.push_back({2'd1, 1'b0});
    async_a[1] = 1'b1; repeat (5) @(negedge clk);
    async_a[1] = 1'b0; repeat (5) @(negedge clk);
    async_a[1] = 1'b1; repeat (5) @(negedge clk);
    async_a[1] = 1'b0; repeat (5) @(negedge clk);
    n_checks++; if ({valid_a, id_a, lvl_a} !== 4'b1011) $display("FAIL ovf_held got %b want 1011", {valid_a, id_a, lvl_a}); else n_pass++;
    n_checks++; if (pend_a !== 4'b0010) $display("FAIL ovf_pending got %b want 0010", pend_a); else n_pass++;
    n_checks++; if (ovf_a !== 4'b0010) $display("FAIL ovf_flag got %b want 0010", ovf_a); else n_pass++;
    clr_a = 4'b0010;
    @(negedge clk);
    clr_a = 4'b0000;
    n_checks++; if (ovf_a !== 4'b0000) $display("FAIL ovf_clear got %b want 0000", ovf_a); else n_pass++;
    n_checks++; if ({valid_a, id_a, lvl_a} !== 4'b1011) $display("FAIL ovf_stable got %b want 1011", {valid_a, id_a, lvl_a}); else n_pass++;
    ready_a = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      if (valid_a && ready_a) begin
        e = q.pop_front();
        n_checks++;
        if ({id_a, lvl_a} !== e) $display("FAIL ovf_event got %b want %b", {id_a, lvl_a}, e); else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++; if (q.size() !== 0) $display("FAIL ovf_timeout got %0d left want 0", q.size()); else n_pass++;
    n_checks++; if (pend_a !== 4'b0000) $display("FAIL ovf_pending_after got %b want 0000", pend_a); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    ready_a = 1'b1;
    async_a[2] = 1'b1;
    q.push_back({2'd2, 1'b1});
    for (int c = 1; c <= 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (valid_a && ready_a) begin
        e = q.pop_front();
        n_checks++;
        if ({id_a, lvl_a} !== e) $display("FAIL rr_first got %b want %b", {id_a, lvl_a}, e); else n_pass++;
      end
    end
    async_a[0] = 1'b1;
    async_a[3] = 1'b1;
    q.push_back({2'd3, 1'b1});
    q.push_back({2'd0, 1'b1});
    for (int c = 1; c <= 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (valid_a && ready_a) begin
        e = q.pop_front();
        n_checks++;
        if ({id_a, lvl_a} !== e) $display("FAIL rr_order got %b want %b", {id_a, lvl_a}, e); else n_pass++;
      end
    end
    n_checks++; if (q.size() !== 0) $display("FAIL rr_timeout got %0d left want 0", q.size()); else n_pass++;
  endtask

  task automatic test_edge_mode_init();
    int nv_r = 0;
    int nv_i = 0;
    do_reset();
    async_r[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid_r) begin
        nv_r++;
        n_checks++; if ({id_r, lvl_r} !== 3'b011) $display("FAIL rise_event got %b want 011", {id_r, lvl_r}); else n_pass++;
      end
      if (valid_i) nv_i++;
    end
    n_checks++; if (nv_r !== 1) $display("FAIL rise_count got %0d want 1", nv_r); else n_pass++;
    nv_r = 0;
    async_r[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid_r) nv_r++;
      if (valid_i) nv_i++;
    end
    n_checks++; if (nv_r !== 0) $display("FAIL fall_ignored got %0d want 0", nv_r); else n_pass++;
    n_checks++; if ({pend_r, ovf_r} !== 8'h00) $display("FAIL fall_pending got %h want 00", {pend_r, ovf_r}); else n_pass++;
    n_checks++; if (nv_i !== 0) $display("FAIL init_events got %0d want 0", nv_i); else n_pass++;
    n_checks++; if ({pend_i, ovf_i} !== 8'h00) $display("FAIL init_pending got %h want 00", {pend_i, ovf_i}); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int c;
    do_reset();
    ready_a = 1'b0;
    async_a[0] = 1'b1;
    for (c = 0; c < 8 && !valid_a; c++) @(negedge clk);
    n_checks++; if (valid_a !== 1'b1) $display("FAIL mid_valid got %b want 1", valid_a); else n_pass++;
    async_a[1] = 1'b1;
    async_a[3] = 1'b1;
    for (c = 0; c < 8 && pend_a !== 4'b1010; c++) @(negedge clk);
    n_checks++; if (pend_a !== 4'b1010) $display("FAIL mid_pending got %b want 1010", pend_a); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (valid_a !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", valid_a); else n_pass++;
    n_checks++; if ({pend_a, ovf_a} !== 8'h00) $display("FAIL mid_rst_pend_ovf got %h want 00", {pend_a, ovf_a}); else n_pass++;
    q.delete();
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_round_robin();
    test_edge_mode_init();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
